// File: rtl/data_bus_mem.sv
// Word-addressed data memory with a posted write buffer and store-to-load forwarding; load data registered one cycle after the load edge.
// No backpressure: a store into a full buffer always coincides with a drain. Optional DMEM_STATS_EN adds saturating rd_cnt/wr_cnt.
module data_bus_mem #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
`ifdef DMEM_STATS_EN
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
`endif
  output logic              wb_empty
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  logic              load;
  logic              store;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;

  assign load       = cs & ~we;
  assign store      = cs & we;
  assign drain      = ~load & (count != '0);
  assign count_next = count + CNT_W'(store) - CNT_W'(drain);

  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (wb_addr[idx] == ADDR)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[idx];
      end
    end
  end

  // Array has no reset; pending entries are dropped rather than retired on reset.
  always_ff @(posedge clock) begin
    if (!reset && drain) begin
      mem[wb_addr[rd_ptr]] <= wb_data[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      wb_empty      <= 1'b1;
      Data_BUS_READ <= '0;
    end else begin
      if (store) begin
        wb_addr[wr_ptr] <= ADDR;
        wb_data[wr_ptr] <= Data_BUS_WRITE;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (load) begin
        Data_BUS_READ <= fwd_hit ? fwd_data : mem[ADDR];
      end
      count    <= count_next;
      wb_empty <= (count_next == '0);
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (load && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
      if (store && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_mem.sv
// Directed bench for data_bus_mem: program-order memory model plus literal spot checks.
// Builds with or without DMEM_STATS_EN.
module tb_data_bus_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [9:0]  ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic [31:0] Data_BUS_READ;
  logic        wb_empty;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`endif

  data_bus_mem #(.ADDR_W(10), .DATA_W(32), .WB_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .cs             (cs),
    .we             (we),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .Data_BUS_READ  (Data_BUS_READ),
`ifdef DMEM_STATS_EN
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt),
`endif
    .wb_empty       (wb_empty)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: committed array contents plus the queue of posted stores, oldest first.
  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } entry_t;

  logic [31:0] arr_m [int];
  entry_t      q_m [$];
  logic [31:0] rd_exp;
  bit          rd_known;
  bit          chk_en = 1'b0;
  int          max_occ = 0;
  int          rd_m = 0;
  int          wr_m = 0;

  task automatic model_step(input logic r, input logic c, input logic w,
                            input logic [9:0] a, input logic [31:0] d);
    bit found;
    if (r) begin
      q_m.delete();
      rd_exp   = '0;
      rd_known = 1'b1;
      rd_m     = 0;
      wr_m     = 0;
    end else if (c && !w) begin
      found = 1'b0;
      for (int i = q_m.size() - 1; i >= 0; i--) begin
        if (!found && q_m[i].a == a) begin
          rd_exp = q_m[i].d;
          found  = 1'b1;
        end
      end
      if (!found) begin
        rd_known = arr_m.exists(int'(a));
        if (rd_known) rd_exp = arr_m[int'(a)];
      end else begin
        rd_known = 1'b1;
      end
      if (rd_m < 65535) rd_m++;
    end else begin
      if (q_m.size() > 0) begin
        arr_m[int'(q_m[0].a)] = q_m[0].d;
        void'(q_m.pop_front());
      end
      if (c) begin
        q_m.push_back('{a: a, d: d});
        if (wr_m < 65535) wr_m++;
      end
    end
    if (q_m.size() > max_occ) max_occ = q_m.size();
  endtask

  task automatic cyc(input logic r, input logic c, input logic w,
                     input logic [9:0] a, input logic [31:0] d);
    reset = r; cs = c; we = w; ADDR = a; Data_BUS_WRITE = d;
    @(posedge clock);
    model_step(r, c, w, a, d);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask
  task automatic st(input logic [9:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, a, d);
  endtask
  task automatic ld(input logic [9:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (wb_empty !== 1'b1 && n < 20) begin
      idle();
      n++;
    end
    vectors++;
    if (wb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: wb_empty still %b after %0d idles, expected 1", name, wb_empty, n);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      vectors++;
      if (wb_empty !== (q_m.size() == 0)) begin
        miscompares++;
        $display("FAIL model_wb_empty @%0t: got %b expected %b", $time, wb_empty, q_m.size() == 0);
      end
      if (rd_known) begin
        vectors++;
        if (Data_BUS_READ !== rd_exp) begin
          miscompares++;
          $display("FAIL model_rdata @%0t: got %h expected %h", $time, Data_BUS_READ, rd_exp);
        end
      end
`ifdef DMEM_STATS_EN
      vectors++;
      if (rd_cnt !== 16'(rd_m) || wr_cnt !== 16'(wr_m)) begin
        miscompares++;
        $display("FAIL model_stats @%0t: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                 $time, rd_cnt, wr_cnt, rd_m, wr_m);
      end
`endif
    end
  end

  initial begin
    rd_known = 1'b0;
    rd_exp   = '0;
    cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    chk_en = 1'b1;
    idle();
    check_lit("reset_rdata", Data_BUS_READ, 32'h0);
    check_lit("reset_wb_empty", {31'b0, wb_empty}, 32'h1);

    // Forwarding from a freshly posted store
    st(10'h005, 32'h12345678);
    check_lit("fwd_wb_nonempty", {31'b0, wb_empty}, 32'h0);
    ld(10'h005);
    check_lit("fwd_load", Data_BUS_READ, 32'h12345678);
    idle();
    check_lit("rdata_hold_idle", Data_BUS_READ, 32'h12345678);

    // Same address twice: newest wins in forwarding and in the array
    st(10'h010, 32'h0000000A);
    st(10'h010, 32'h0000000B);
    ld(10'h010);
    check_lit("same_addr_fwd", Data_BUS_READ, 32'h0000000B);
    wait_empty("same_addr_drain");
    ld(10'h010);
    check_lit("same_addr_array", Data_BUS_READ, 32'h0000000B);

    // Five back-to-back stores
    for (int i = 0; i < 5; i++) st(10'h020 + 10'(i), 32'h100 + 32'(i));
    wait_empty("five_drain");
    for (int i = 0; i < 5; i++) begin
      ld(10'h020 + 10'(i));
      check_lit("five_load", Data_BUS_READ, 32'h100 + 32'(i));
    end
    check_lit("occupancy_le_4", 32'(max_occ <= 4), 32'h1);

    // Back-to-back loads starve draining
    st(10'h031, 32'h00000031);
    wait_empty("pre_031");
    st(10'h030, 32'h00000077);
    for (int i = 0; i < 8; i++) begin
      ld(10'h031);
      check_lit("starve_wb_empty", {31'b0, wb_empty}, 32'h0);
    end
    check_lit("starve_other_addr", Data_BUS_READ, 32'h00000031);
    ld(10'h030);
    check_lit("starve_fwd", Data_BUS_READ, 32'h00000077);
    idle();
    check_lit("starve_drained", {31'b0, wb_empty}, 32'h1);

    // Mid-stream reset drops pending stores; reset dominates a store
    st(10'h040, 32'h00001111);
    st(10'h041, 32'h00002222);
    wait_empty("pre_reset");
    st(10'h041, 32'h0000BEEF);
    st(10'h040, 32'h0000DEAD);
    cyc(1'b1, 1'b1, 1'b1, 10'h041, 32'hFFFFFFFF);
    check_lit("midreset_empty", {31'b0, wb_empty}, 32'h1);
    check_lit("midreset_rdata", Data_BUS_READ, 32'h0);
    ld(10'h040);
    check_lit("midreset_lost", Data_BUS_READ, 32'h00001111);
    ld(10'h041);
    check_lit("midreset_kept", Data_BUS_READ, 32'h0000BEEF);

`ifdef DMEM_STATS_EN
    cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    st(10'h050, 32'h1);
    st(10'h051, 32'h2);
    st(10'h052, 32'h3);
    ld(10'h050);
    ld(10'h051);
    for (int i = 0; i < 4; i++) idle();
    check_lit("stats_wr", {16'h0, wr_cnt}, 32'd3);
    check_lit("stats_rd", {16'h0, rd_cnt}, 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
    check_lit("stats_reset", {rd_cnt, wr_cnt}, 32'h0);
`endif

    idle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
